// File: rtl/gpgll_frame_ctrl.sv
// gpgll_frame_ctrl
//   Byte-level GPGLL sentence sequencer. Tracks framing ($, header, fields,
//   '*', two hex checksum digits), stages latitude/longitude minutes, UTC
//   hh:mm and fix flag in shadow registers, and commits them to the outputs
//   only when the sentence is complete and its XOR checksum matches.
//
// Ports
//   Clk, Reset           clock, asynchronous active-high reset
//   enable               parser enable (low: IDLE, bytes ignored)
//   rx_data, rx_valid    received byte and its single-cycle strobe
//   lat_min, lon_min     committed minutes, binary 0-99
//   time_bcd             committed {h1,h0,m1,m0} BCD UTC time
//   fix_valid            field 6 was 'A' in the last committed sentence
//   frame_done           one-cycle pulse on commit
//   frame_err            one-cycle pulse on checksum/format/timeout failure
//   busy                 state is not IDLE
module gpgll_frame_ctrl #(
  parameter int unsigned GAP_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  lat_min,
  output logic [7:0]  lon_min,
  output logic [15:0] time_bcd,
  output logic        fix_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FIELDS, S_CK_HI, S_CK_LO} state_t;

  localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_hdr_idx;
  logic [7:0]  r_xor;
  logic [3:0]  r_field, r_chr;
  logic [3:0]  r_d1, r_d0, r_ck_hi;
  logic [7:0]  r_lat_sh, r_lon_sh;
  logic [15:0] r_time_sh;
  logic        r_lat_seen, r_lon_seen, r_time_seen, r_fix_sh;
  logic [GW-1:0] r_gap;

  logic        w_done, w_err, w_restart, w_gap_hit;
  logic [7:0]  w_hdr_exp;
  logic        w_hex_ok;
  logic [3:0]  w_hex_val;
  logic        w_digit;
  logic [7:0]  w_min;

  assign busy      = (r_state != S_IDLE);
  assign w_gap_hit = (r_gap == GW'(GAP_CYCLES - 1));
  assign w_digit   = (rx_data >= "0") && (rx_data <= "9");
  // d1*10 + d0 as shifts and adds
  assign w_min     = {1'b0, r_d1, 3'b0} + {3'b0, r_d1, 1'b0} + {4'b0, r_d0};

  always_comb begin
    w_hdr_exp = "L";
    case (r_hdr_idx)
      3'd0:    w_hdr_exp = "G";
      3'd1:    w_hdr_exp = "P";
      3'd2:    w_hdr_exp = "G";
      default: w_hdr_exp = "L";
    endcase
  end

  always_comb begin
    w_hex_ok  = 1'b0;
    w_hex_val = rx_data[3:0];
    if (w_digit) begin
      w_hex_ok = 1'b1;
    end else if ((rx_data >= "A") && (rx_data <= "F")) begin
      w_hex_ok  = 1'b1;
      w_hex_val = rx_data[3:0] + 4'd9;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_restart  = 1'b0;
    if (!enable) begin
      w_state_nx = S_IDLE;
    end else if (rx_valid) begin
      if (rx_data == "$") begin
        w_restart  = 1'b1;
        w_state_nx = S_HDR;
      end else begin
        case (r_state)
          S_HDR: begin
            if (rx_data != w_hdr_exp)   w_state_nx = S_IDLE;
            else if (r_hdr_idx == 3'd4) w_state_nx = S_FIELDS;
          end
          S_FIELDS: if (rx_data == "*") w_state_nx = S_CK_HI;
          S_CK_HI: begin
            if (w_hex_ok) begin
              w_state_nx = S_CK_LO;
            end else begin
              w_state_nx = S_IDLE;
              w_err      = 1'b1;
            end
          end
          S_CK_LO: begin
            w_state_nx = S_IDLE;
            if (w_hex_ok && ({r_ck_hi, w_hex_val} == r_xor) &&
                r_lat_seen && r_lon_seen && r_time_seen)
              w_done = 1'b1;
            else
              w_err = 1'b1;
          end
          default: ;
        endcase
      end
    end else if ((r_state != S_IDLE) && w_gap_hit) begin
      w_state_nx = S_IDLE;
      w_err      = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      frame_done <= w_done;
      frame_err  <= w_err;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_gap       <= '0;
      r_hdr_idx   <= '0;
      r_xor       <= '0;
      r_field     <= '0;
      r_chr       <= '0;
      r_d1        <= '0;
      r_d0        <= '0;
      r_ck_hi     <= '0;
      r_lat_sh    <= '0;
      r_lon_sh    <= '0;
      r_time_sh   <= '0;
      r_lat_seen  <= 1'b0;
      r_lon_seen  <= 1'b0;
      r_time_seen <= 1'b0;
      r_fix_sh    <= 1'b0;
      lat_min     <= '0;
      lon_min     <= '0;
      time_bcd    <= '0;
      fix_valid   <= 1'b0;
    end else begin
      if (!enable || rx_valid || (r_state == S_IDLE) || w_gap_hit)
        r_gap <= '0;
      else
        r_gap <= r_gap + 1'b1;

      if (enable && rx_valid) begin
        if (w_restart) begin
          r_hdr_idx   <= '0;
          r_xor       <= '0;
          r_field     <= '0;
          r_chr       <= '0;
          r_d1        <= '0;
          r_d0        <= '0;
          r_lat_sh    <= '0;
          r_lon_sh    <= '0;
          r_time_sh   <= '0;
          r_lat_seen  <= 1'b0;
          r_lon_seen  <= 1'b0;
          r_time_seen <= 1'b0;
          r_fix_sh    <= 1'b0;
        end else begin
          case (r_state)
            S_HDR: begin
              if (rx_data == w_hdr_exp) begin
                r_xor     <= r_xor ^ rx_data;
                r_hdr_idx <= r_hdr_idx + 3'd1;
              end
            end
            S_FIELDS: begin
              if (rx_data != "*") begin
                r_xor <= r_xor ^ rx_data;
                if (rx_data == ",") begin
                  if (r_field != 4'hF) r_field <= r_field + 4'd1;
                  r_chr <= '0;
                  r_d1  <= '0;
                  r_d0  <= '0;
                end else begin
                  if (r_chr != 4'hF) r_chr <= r_chr + 4'd1;
                  case (r_field)
                    4'd1, 4'd3: begin
                      if (w_digit) begin
                        r_d1 <= r_d0;
                        r_d0 <= rx_data[3:0];
                      end else if (rx_data == ".") begin
                        if (r_field == 4'd1) begin
                          r_lat_sh   <= w_min;
                          r_lat_seen <= 1'b1;
                        end else begin
                          r_lon_sh   <= w_min;
                          r_lon_seen <= 1'b1;
                        end
                      end
                    end
                    4'd5: begin
                      case (r_chr)
                        4'd0: r_time_sh[15:12] <= rx_data[3:0];
                        4'd1: r_time_sh[11:8]  <= rx_data[3:0];
                        4'd2: r_time_sh[7:4]   <= rx_data[3:0];
                        4'd3: begin
                          r_time_sh[3:0] <= rx_data[3:0];
                          r_time_seen    <= 1'b1;
                        end
                        default: ;
                      endcase
                    end
                    4'd6: if (r_chr == 4'd0) r_fix_sh <= (rx_data == "A");
                    default: ;
                  endcase
                end
              end
            end
            S_CK_HI: r_ck_hi <= w_hex_val;
            S_CK_LO: begin
              if (w_done) begin
                lat_min   <= r_lat_sh;
                lon_min   <= r_lon_sh;
                time_bcd  <= r_time_sh;
                fix_valid <= r_fix_sh;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gpgll_frame_ctrl.sv
module tb_gpgll_frame_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, enable, rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  lat_min, lon_min;
  logic [15:0] time_bcd;
  logic        fix_valid, frame_done, frame_err, busy;

  always #5 Clk = ~Clk;

  gpgll_frame_ctrl #(.GAP_CYCLES(100)) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .lat_min(lat_min), .lon_min(lon_min), .time_bcd(time_bcd),
    .fix_valid(fix_valid), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy)
  );

  typedef struct {
    bit          done;
    logic [7:0]  lat;
    logic [7:0]  lon;
    logic [15:0] tm;
    bit          fix;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] xsum(string s);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < s.len(); i++) x ^= s[i];
    return x;
  endfunction

  task automatic send_byte(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge Clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_gll(string body, logic [7:0] adj);
    logic [7:0] ck;
    ck = xsum(body) + adj;
    send_byte("$");
    send_str(body);
    send_byte("*");
    send_byte(hexc(ck[7:4]));
    send_byte(hexc(ck[3:0]));
  endtask

  task automatic expect_ev(bit done, logic [7:0] lat, logic [7:0] lon,
                           logic [15:0] tm, bit fix);
    exp_t e;
    e.done = done; e.lat = lat; e.lon = lon; e.tm = tm; e.fix = fix;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (frame_done || frame_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'b0, frame_done, frame_err}, 32'd0);
      end else begin
        m_e = sb.pop_front();
        chk("pulse_kind", {30'b0, frame_done, frame_err}, {30'b0, m_e.done, !m_e.done});
        chk("lat_min",   {24'b0, lat_min},   {24'b0, m_e.lat});
        chk("lon_min",   {24'b0, lon_min},   {24'b0, m_e.lon});
        chk("time_bcd",  {16'b0, time_bcd},  {16'b0, m_e.tm});
        chk("fix_valid", {31'b0, fix_valid}, {31'b0, m_e.fix});
      end
    end
  end

  localparam string GLL_A = "GPGLL,3723.2445,N,2158.3438,W,161229.487,A,A";

  initial begin
    int n;
    Reset    = 1'b1;
    enable   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_lat",  {24'b0, lat_min},  32'd0);
    chk("rst_lon",  {24'b0, lon_min},  32'd0);
    chk("rst_time", {16'b0, time_bcd}, 32'd0);
    chk("rst_fix",  {31'b0, fix_valid}, 32'd0);
    chk("rst_pulses", {30'b0, frame_done, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Valid sentence, then the same with a bad checksum, back-to-back
    expect_ev(1'b1, 8'd23, 8'd58, 16'h1612, 1'b1);
    send_gll(GLL_A, 8'd0);
    expect_ev(1'b0, 8'd23, 8'd58, 16'h1612, 1'b1);
    send_gll(GLL_A, 8'd1);
    repeat (3) @(posedge Clk);
    #1;
    chk("idle_after_err_busy", {31'b0, busy}, 32'd0);

    // Non-GLL sentence ignored, then GLL with new values
    send_str("$GPRMC,161229.487,A,3723.2445,N,12158.3438,W,0.13,309.62,120598,,*10");
    chk("rmc_busy", {31'b0, busy}, 32'd0);
    expect_ev(1'b1, 8'd12, 8'd31, 16'h0925, 1'b0);
    send_gll("GPGLL,4512.0000,S,0731.5000,E,092512.000,V,A", 8'd0);

    // Restart mid-field 3
    send_str("$GPGLL,3723.2445,N,21");
    expect_ev(1'b1, 8'd12, 8'd45, 16'h2359, 1'b1);
    send_gll("GPGLL,4512.1,N,0745.9,E,235959,A,A", 8'd0);

    // Non-hex checksum character
    expect_ev(1'b0, 8'd12, 8'd45, 16'h2359, 1'b1);
    send_str("$GPGLL,1111.1,N,2222.2,W,1111,A,A*G");
    @(posedge Clk);
    #1;
    chk("nonhex_busy", {31'b0, busy}, 32'd0);

    // Truncated sentence then idle gap
    expect_ev(1'b0, 8'd12, 8'd45, 16'h2359, 1'b1);
    send_str("$GPGLL,3723.2445,N,2158.3438,");
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!frame_err && n < 300);
    chk("timeout_latency", n, 32'd101);
    chk("timeout_busy", {31'b0, busy}, 32'd0);

    // Disabled parser ignores a full valid sentence
    @(posedge Clk);
    #1;
    enable = 1'b0;
    send_gll(GLL_A, 8'd0);
    chk("disabled_busy", {31'b0, busy}, 32'd0);
    enable = 1'b1;
    repeat (3) @(posedge Clk);
    #1;

    // Reset during field 5
    send_str("$GPGLL,1111.1,N,2222.2,W,12");
    Reset = 1'b1;
    #1;
    chk("midrst_lat",  {24'b0, lat_min},  32'd0);
    chk("midrst_lon",  {24'b0, lon_min},  32'd0);
    chk("midrst_time", {16'b0, time_bcd}, 32'd0);
    chk("midrst_fix",  {31'b0, fix_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    expect_ev(1'b1, 8'd34, 8'd76, 16'h0730, 1'b1);
    send_gll("GPGLL,1234.5,N,09876.5,W,0730,A,A", 8'd0);

    repeat (10) @(posedge Clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpgll_frame_ctrl.md
# gpgll_frame_ctrl

Byte-level sequencer between the GPS UART receiver and the display/compare logic of the final project. It consumes one received byte per `rx_valid` strobe and tracks sentence framing (`$`, header, comma-delimited fields, `*`, checksum). It stages latitude/longitude minutes and the UTC hh:mm into shadow registers, and commits them to its outputs only when a complete GPGLL sentence passes its XOR checksum.

## Interface
- `GAP_CYCLES`, 50000: idle clocks allowed between bytes of one sentence (1 ms at 50 MHz) before the frame is abandoned.
- `Clk`  in  1  system clock (MAX10_CLK1_50 domain).
- `Reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  parser enable; low forces IDLE and ignores bytes.
- `rx_data`  in  8  received byte, valid only with `rx_valid`.
- `rx_valid`  in  1  single-cycle strobe, one per received byte.
- `lat_min`  out  8  latitude minutes, binary 0–99.
- `lon_min`  out  8  longitude minutes, binary 0–99.
- `time_bcd`  out  16  {h1,h0,m1,m0} BCD UTC time.
- `fix_valid`  out  1  field 6 was `A` in the last committed sentence.
- `frame_done`  out  1  one-cycle pulse on commit.
- `frame_err`  out  1  one-cycle pulse on checksum, format or timeout failure.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE → HDR on `$`.
  - HDR → FIELDS after matching `G`,`P`,`G`,`L`,`L` in order.
  - FIELDS → CK_HI on `*`.
  - CK_HI → CK_LO on any valid hex character.
  - CK_LO → IDLE on any valid hex character, then commit or error.
- Any mismatching header byte returns to IDLE silently, with no `frame_err`. Non-GPGLL sentences are ignored.
- `$` received in any non-IDLE state restarts the frame (→ HDR, shadow state cleared). No `frame_err`.
- Checksum: XOR of every byte strictly between `$` and `*`. The 8-bit accumulator is cleared on `$`.
- Hex digits: `0`–`9` and `A`–`F` only. Any other byte in CK_HI or CK_LO gives `frame_err` and returns to IDLE.
- Field index:
  - Starts at 0 (the header) and increments on each `,`. Saturates at 15.
  - Per-field character counter saturates at 15; it is cleared on `,`.
- Fields 1 and 3 (minutes):
  - Keep the last two digit characters received in the field.
  - On `.`, latch (d1·10 + d0) into shadow min and set that field's seen-flag.
- Field 5 (time): characters 0–3 are latched into shadow BCD; set the seen-flag when the count reaches 4.
- Field 6: shadow fix = (first char == `A`).
- Commit requires three conditions: received checksum == accumulator, both minute seen-flags, and the time seen-flag.
  - Met: shadow values are copied to the outputs and `frame_done` pulses.
  - Not met: `frame_err` pulses and the outputs hold their previous values.
- Timeout: in any non-IDLE state, a counter of cycles without `rx_valid` reaching `GAP_CYCLES` gives `frame_err` and IDLE.
- `enable` low: IDLE next cycle, no pulses, outputs held.

## Timing
- Reset values: all outputs 0; state IDLE; shadow registers, accumulator and counters 0.
- All state updates happen on the `Clk` edge where `rx_valid` is high. No backpressure; bytes are never dropped.
- Back-to-back `rx_valid` on consecutive cycles must be accepted.
- `frame_done`/`frame_err` are registered. They are high for exactly the cycle after the edge that sampled the final checksum byte.
- Output registers change on that same edge.
- `busy` drops on the same edge.
- A `$` on the cycle after the commit edge starts a new frame normally.
- Reset asserted mid-frame: immediate IDLE, all outputs 0, no pulse on release.

## Test plan
- `$GPGLL,3723.2445,N,2158.3438,W,161229.487,A,A*hh`, with hh = correct XOR computed by the bench, sent back-to-back → one `frame_done`; `lat_min`=23, `lon_min`=58, `time_bcd`=16'h1612, `fix_valid`=1.
- Same sentence with hh off by one → one `frame_err`, no `frame_done`, outputs unchanged from the prior commit (or 0 after reset).
- `$GPRMC,...*hh` followed by a valid GPGLL → no pulse for RMC, `frame_done` for GLL, values from GLL.
- GPGLL truncated after field 3 with `GAP_CYCLES`=100 and a 200-cycle idle gap → `frame_err` 100 cycles after the last byte, `busy`=0.
- Valid sentence interrupted by `$` mid-field 3, then a full valid sentence with lat 4512 → no error, `lat_min`=12.
- `Reset` pulsed during field 5 of a valid sentence → outputs 0, no pulse, IDLE. A following valid sentence commits normally.
